// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline (A) and the long-latency unit (B)
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   a_valid/a_ready, a_rd            port A handshake and destination register
//   a_exc_data, a_mem_data, a_is_load   port A execute/load result and load select
//   b_valid/b_ready, b_rd, b_data    port B handshake, destination register and result
//   rf_wen, rf_waddr, rf_wdata, rf_src  registered register-file write and winning port
//   perf_wb_a, perf_wb_b             per-port handshake counters (wrapping)
module wb_port_arbiter #(
    parameter int XLEN       = 64,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [4:0]        a_rd,
    input  logic [XLEN-1:0]   a_exc_data,
    input  logic [XLEN-1:0]   a_mem_data,
    input  logic              a_is_load,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [4:0]        b_rd,
    input  logic [XLEN-1:0]   b_data,
    output logic              rf_wen,
    output logic [4:0]        rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              rf_src,
    output logic [PERF_W-1:0] perf_wb_a,
    output logic [PERF_W-1:0] perf_wb_b
);
    localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);
    logic [CNT_W-1:0] starve_cnt;
    logic             hs;
    logic [4:0]       sel_rd;
    logic [XLEN-1:0]  sel_data;
    // A wins ties until B has waited STARVE_MAX cycles
    assign b_ready  = b_valid && (!a_valid || starve_cnt == SMAX);
    assign a_ready  = a_valid && !b_ready;
    assign hs       = a_ready || b_ready;
    assign sel_rd   = b_ready ? b_rd : a_rd;
    assign sel_data = b_ready ? b_data : (a_is_load ? a_mem_data : a_exc_data);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rf_src     <= 1'b0;
            perf_wb_a  <= '0;
            perf_wb_b  <= '0;
            starve_cnt <= '0;
        end else begin
            rf_wen <= hs && sel_rd != 5'd0;
            if (hs) begin
                rf_waddr <= sel_rd;
                rf_wdata <= sel_data;
                rf_src   <= b_ready;
            end
            if (a_ready) perf_wb_a <= perf_wb_a + 1'b1;
            if (b_ready) perf_wb_b <= perf_wb_b + 1'b1;
            starve_cnt <= (!b_valid || b_ready) ? '0 :
                          (starve_cnt == SMAX) ? starve_cnt : starve_cnt + 1'b1;
        end
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single integer register-file write port between two result sources.
- Port A is the in-order pipeline result: execute data, or load data when the instruction is a load.
- Port B is the long-latency unit completion (multiply/divide).
- Arbitrates between the ports with starvation protection and drives a registered write to the register file with one cycle of latency. Also keeps per-port writeback performance counters.

Parameters:
- XLEN, 64, datapath width.
- STARVE_MAX, 4, consecutive stalled cycles of port B before B gets priority over A (1..2^CNT_W-1).
- CNT_W, 3, width of the starvation counter.
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  port A result present.
- a_ready  out  1  port A accepted this cycle.
- a_rd  in  5  port A destination register.
- a_exc_data  in  XLEN  execute-stage result.
- a_mem_data  in  XLEN  load data from the memory stage.
- a_is_load  in  1  1 selects a_mem_data, 0 selects a_exc_data.
- b_valid  in  1  port B result present.
- b_ready  out  1  port B accepted this cycle.
- b_rd  in  5  port B destination register.
- b_data  in  XLEN  port B result.
- rf_wen  out  1  register-file write enable (registered).
- rf_waddr  out  5  write address (registered).
- rf_wdata  out  XLEN  write data (registered).
- rf_src  out  1  source of the current write: 0 = A, 1 = B (registered).
- perf_wb_a  out  PERF_W  count of port A handshakes.
- perf_wb_b  out  PERF_W  count of port B handshakes.

Behaviour:
- Reset (rst_n low, asynchronous): rf_wen, rf_waddr, rf_wdata, rf_src, perf_wb_a, perf_wb_b and starve_cnt all go to 0. Deassertion is synchronised externally.
- Grant (combinational):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant B if starve_cnt == STARVE_MAX, else grant A.
  - Neither valid: no grant.
- a_ready = grant A; b_ready = grant B. Ready depends on valid. Requesters must not make valid depend on ready.
- Exactly one handshake per cycle, at most. a_ready and b_ready are never both 1.
- Write register update on a handshake at edge N, visible in cycle N+1 (latency 1):
  - rf_wen = (rd != 0).
  - rf_waddr = rd.
  - rf_wdata = selected data: for A, a_is_load ? a_mem_data : a_exc_data; for B, b_data.
  - rf_src = winning port.
- Writes with rd == 0 still complete the handshake and count in the perf counters. rf_wen stays 0, but rf_waddr and rf_wdata still update.
- No handshake: rf_wen = 0 next cycle; rf_waddr, rf_wdata and rf_src hold their values.
- starve_cnt update:
  - Increment (saturating at STARVE_MAX) when b_valid and not b_ready.
  - Clear to 0 when a B handshake occurs or b_valid = 0.
- Starvation bound: B waits at most STARVE_MAX cycles while A is continuously valid. In cycle STARVE_MAX+1 of waiting, B is granted.
- Write order equals grant order. The issue logic guarantees no same-rd hazard between pending A and B results. The arbiter does no rd comparison.
- Perf counters increment by 1 on their port's handshake and wrap modulo 2^PERF_W.
- Reset asserted mid-stream drops any in-flight registered write: rf_wen is 0 immediately.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no valids for 5 cycles -> all outputs 0 throughout, a_ready = b_ready = 0.
- A only, load vs ALU:
  - a_valid=1, a_rd=5, a_is_load=0, a_exc_data=0x11 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x11, rf_src=0.
  - Then a_is_load=1, a_mem_data=0x22 -> rf_wdata=0x22.
- x0 suppression: B with b_rd=0, b_data=0xFF -> b_ready=1, next cycle rf_wen=0, perf_wb_b increments to 1.
- Contention: A and B both held valid continuously, STARVE_MAX=4 -> A granted cycles 0-3, B granted cycle 4, rf_src=1 in cycle 5, starve_cnt back to 0.
- B only back-to-back: b_valid held 3 cycles with rd=1,2,3 -> three consecutive rf_wen pulses with waddr 1,2,3; perf_wb_b=3.
- Reset mid-operation: assert rst_n low while rf_wen=1 and starve_cnt=2 -> rf_wen and starve_cnt are 0 immediately, before the next clock edge.
